// File: rtl/spi_fetch_sched_if.sv
// Client request/byte-delivery and SPI reader control signals of the fetch scheduler.
// The scheduler connects through the slave modport; the driving side uses master.
interface spi_fetch_sched_if #(
  parameter int unsigned LEN_W = 8
);
  logic [1:0]       IN_req;
  logic [23:0]      IN_addr0;
  logic [23:0]      IN_addr1;
  logic [LEN_W-1:0] IN_len0;
  logic [LEN_W-1:0] IN_len1;
  logic [1:0]       IN_abort;
  logic [1:0]       OUT_ack;
  logic [7:0]       OUT_byte;
  logic [1:0]       OUT_byteValid;
  logic [1:0]       OUT_done;
  logic             OUT_busy;
  logic [23:0]      OUT_spiAddr;
  logic             OUT_spiRead;
  logic             OUT_spiCancel;
  logic             IN_spiData;
  logic             IN_spiValid;
  logic             IN_spiByte;

  modport master (
    output IN_req, IN_addr0, IN_addr1, IN_len0, IN_len1, IN_abort,
    output IN_spiData, IN_spiValid, IN_spiByte,
    input  OUT_ack, OUT_byte, OUT_byteValid, OUT_done, OUT_busy,
    input  OUT_spiAddr, OUT_spiRead, OUT_spiCancel
  );

  modport slave (
    input  IN_req, IN_addr0, IN_addr1, IN_len0, IN_len1, IN_abort,
    input  IN_spiData, IN_spiValid, IN_spiByte,
    output OUT_ack, OUT_byte, OUT_byteValid, OUT_done, OUT_busy,
    output OUT_spiAddr, OUT_spiRead, OUT_spiCancel
  );
endinterface

// File: rtl/spi_fetch_sched.sv
// Two-client round-robin burst scheduler for a bit-serial SPI EEPROM reader.
// Assembles MSB-first bytes, routes them to the owner, and closes each burst with cancel + gap.
module spi_fetch_sched #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  spi_fetch_sched_if.slave  bus
);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StStream, StCancel, StGap} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic             abort_q, abort_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [1:0]       ack_q, ack_d;
  logic             read_q, read_d;
  logic             cancel_q, cancel_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       bv_q, bv_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      abort_q  <= 1'b0;
      gap_q    <= '0;
      ack_q    <= '0;
      read_q   <= 1'b0;
      cancel_q <= 1'b0;
      byte_q   <= '0;
      bv_q     <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      abort_q  <= abort_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      read_q   <= read_d;
      cancel_q <= cancel_d;
      byte_q   <= byte_d;
      bv_q     <= bv_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    abort_d  = abort_q;
    gap_d    = gap_q;
    byte_d   = byte_q;
    ack_d    = '0;
    read_d   = 1'b0;
    cancel_d = 1'b0;
    bv_d     = '0;
    done_d   = '0;
    // Tie goes to the client not served last.
    unique case (bus.IN_req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (|bus.IN_req) begin
          owner_d      = win;
          last_d       = win;
          addr_d       = win ? bus.IN_addr1 : bus.IN_addr0;
          cnt_d        = win ? bus.IN_len1 : bus.IN_len0;
          ack_d[win]   = 1'b1;
          read_d       = 1'b1;
          state_d      = StStart;
        end
      end
      StStart: begin
        sh_d    = '0;
        abort_d = bus.IN_abort[owner_q];
        state_d = StStream;
      end
      StStream: begin
        if (bus.IN_abort[owner_q]) abort_d = 1'b1;
        if (bus.IN_spiValid) begin
          // A pending abort wins over a byte completing on the same cycle.
          if (abort_q) begin
            cancel_d = 1'b1;
            state_d  = StCancel;
          end else begin
            sh_d = {sh_q[6:0], bus.IN_spiData};
            if (bus.IN_spiByte) begin
              byte_d       = {sh_q[6:0], bus.IN_spiData};
              bv_d[owner_q] = 1'b1;
              if (cnt_q == '0) begin
                done_d[owner_q] = 1'b1;
                cancel_d        = 1'b1;
                state_d         = StCancel;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
          end
        end
      end
      StCancel: begin
        gap_d   = GapW'(GAP_CYCLES - 1);
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  assign bus.OUT_ack       = ack_q;
  assign bus.OUT_byte      = byte_q;
  assign bus.OUT_byteValid = bv_q;
  assign bus.OUT_done      = done_q;
  assign bus.OUT_busy      = busy_q;
  assign bus.OUT_spiAddr   = addr_q;
  assign bus.OUT_spiRead   = read_q;
  assign bus.OUT_spiCancel = cancel_q;
endmodule

// File: tb/tb_spi_fetch_sched.sv
// Directed bench for spi_fetch_sched: single, multi-byte, round-robin, aborts and reset.
module tb_spi_fetch_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cancels = 0;
  int   c0;

  spi_fetch_sched_if #(.LEN_W(8)) bus ();

  spi_fetch_sched #(.LEN_W(8), .GAP_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.OUT_spiCancel === 1'b1) cancels++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Streams one byte MSB first on consecutive cycles; returns on the output cycle.
  task automatic feed_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.IN_spiValid = 1'b1;
      bus.IN_spiData  = b[i];
      bus.IN_spiByte  = (i == 0);
      tick();
    end
    bus.IN_spiValid = 1'b0;
    bus.IN_spiData  = 1'b0;
    bus.IN_spiByte  = 1'b0;
  endtask

  initial begin
    bus.IN_req = '0;      bus.IN_abort = '0;
    bus.IN_addr0 = '0;    bus.IN_addr1 = '0;
    bus.IN_len0 = '0;     bus.IN_len1 = '0;
    bus.IN_spiData = 1'b0; bus.IN_spiValid = 1'b0; bus.IN_spiByte = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ack", 32'(bus.OUT_ack), 32'h0);
    chk("rst_busy", 32'(bus.OUT_busy), 32'h0);
    chk("rst_addr", 32'(bus.OUT_spiAddr), 32'h0);
    chk("rst_bv", 32'(bus.OUT_byteValid), 32'h0);

    // Single request, len 0.
    bus.IN_req = 2'b01; bus.IN_addr0 = 24'h012345; bus.IN_len0 = 8'd0;
    tick();
    chk("s_ack", 32'(bus.OUT_ack), 32'h1);
    chk("s_read", 32'(bus.OUT_spiRead), 32'h1);
    chk("s_addr", 32'(bus.OUT_spiAddr), 32'h012345);
    chk("s_busy", 32'(bus.OUT_busy), 32'h1);
    bus.IN_req = 2'b00;
    tick();
    chk("s_ack_pulse", 32'(bus.OUT_ack), 32'h0);
    c0 = cancels;
    feed_byte(8'hA5);
    chk("s_byte", 32'(bus.OUT_byte), 32'hA5);
    chk("s_bv", 32'(bus.OUT_byteValid), 32'h1);
    chk("s_done", 32'(bus.OUT_done), 32'h1);
    chk("s_cancel", 32'(bus.OUT_spiCancel), 32'h1);
    tick();
    chk("s_gap1_busy", 32'(bus.OUT_busy), 32'h1);
    chk("s_gap1_bv", 32'(bus.OUT_byteValid), 32'h0);
    tick();
    chk("s_gap2_busy", 32'(bus.OUT_busy), 32'h1);
    tick();
    chk("s_idle_busy", 32'(bus.OUT_busy), 32'h0);
    chk("s_cancel_cnt", 32'(cancels - c0), 32'h1);

    // Multi-byte burst from client 1.
    bus.IN_req = 2'b10; bus.IN_addr1 = 24'hABCDEF; bus.IN_len1 = 8'd3;
    tick();
    chk("m_ack", 32'(bus.OUT_ack), 32'h2);
    chk("m_addr", 32'(bus.OUT_spiAddr), 32'hABCDEF);
    bus.IN_req = 2'b00;
    tick();
    c0 = cancels;
    feed_byte(8'h11);
    chk("m_b0", 32'(bus.OUT_byte), 32'h11);
    chk("m_bv0", 32'(bus.OUT_byteValid), 32'h2);
    chk("m_nodone0", 32'(bus.OUT_done), 32'h0);
    feed_byte(8'h22);
    chk("m_b1", 32'(bus.OUT_byte), 32'h22);
    chk("m_bv1", 32'(bus.OUT_byteValid), 32'h2);
    feed_byte(8'h33);
    chk("m_b2", 32'(bus.OUT_byte), 32'h33);
    chk("m_nocancel2", 32'(bus.OUT_spiCancel), 32'h0);
    feed_byte(8'h44);
    chk("m_b3", 32'(bus.OUT_byte), 32'h44);
    chk("m_bv3", 32'(bus.OUT_byteValid), 32'h2);
    chk("m_done", 32'(bus.OUT_done), 32'h2);
    repeat (3) tick();
    chk("m_idle", 32'(bus.OUT_busy), 32'h0);
    chk("m_cancel_cnt", 32'(cancels - c0), 32'h1);

    // Round robin with both requesting; last served was client 1.
    bus.IN_req = 2'b11; bus.IN_len0 = 8'd0; bus.IN_len1 = 8'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ack", 32'(bus.OUT_ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      feed_byte(8'h50 + 8'(k));
      chk("rr_done", 32'(bus.OUT_done), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_byte", 32'(bus.OUT_byte), 32'h50 + 32'(k));
      for (int g = 0; g < 3; g++) begin
        tick();
        chk("rr_no_early_ack", 32'(bus.OUT_ack), 32'h0);
      end
    end
    bus.IN_req = 2'b00;

    // Early abort during START.
    bus.IN_req = 2'b01; bus.IN_addr0 = 24'h000100; bus.IN_len0 = 8'd3;
    tick();
    chk("ea_ack", 32'(bus.OUT_ack), 32'h1);
    bus.IN_req = 2'b00; bus.IN_abort = 2'b01;
    tick();
    bus.IN_abort = 2'b00;
    tick();
    chk("ea_wait_cancel", 32'(bus.OUT_spiCancel), 32'h0);
    bus.IN_spiValid = 1'b1; bus.IN_spiData = 1'b1;
    tick();
    bus.IN_spiValid = 1'b0; bus.IN_spiData = 1'b0;
    chk("ea_cancel", 32'(bus.OUT_spiCancel), 32'h1);
    chk("ea_bv", 32'(bus.OUT_byteValid), 32'h0);
    chk("ea_done", 32'(bus.OUT_done), 32'h0);
    repeat (3) tick();
    chk("ea_idle", 32'(bus.OUT_busy), 32'h0);

    // Mid-burst abort, with a non-owner abort first.
    bus.IN_req = 2'b10; bus.IN_addr1 = 24'h000200; bus.IN_len1 = 8'd7;
    tick();
    chk("ma_ack", 32'(bus.OUT_ack), 32'h2);
    bus.IN_req = 2'b00;
    tick();
    bus.IN_abort = 2'b01;
    tick();
    bus.IN_abort = 2'b00;
    feed_byte(8'hC3);
    chk("ma_b0", 32'(bus.OUT_byte), 32'hC3);
    chk("ma_bv0", 32'(bus.OUT_byteValid), 32'h2);
    feed_byte(8'h3C);
    chk("ma_b1", 32'(bus.OUT_byte), 32'h3C);
    chk("ma_bv1", 32'(bus.OUT_byteValid), 32'h2);
    bus.IN_abort = 2'b10;
    tick();
    bus.IN_abort = 2'b00;
    bus.IN_spiValid = 1'b1; bus.IN_spiData = 1'b1;
    tick();
    bus.IN_spiValid = 1'b0; bus.IN_spiData = 1'b0;
    chk("ma_cancel", 32'(bus.OUT_spiCancel), 32'h1);
    chk("ma_bv", 32'(bus.OUT_byteValid), 32'h0);
    chk("ma_done", 32'(bus.OUT_done), 32'h0);
    repeat (3) tick();
    chk("ma_idle", 32'(bus.OUT_busy), 32'h0);

    // Reset in the middle of a client 0 burst.
    bus.IN_req = 2'b01; bus.IN_addr0 = 24'h00F00D; bus.IN_len0 = 8'd5;
    tick();
    chk("rs_ack", 32'(bus.OUT_ack), 32'h1);
    bus.IN_req = 2'b00;
    tick();
    feed_byte(8'h5A);
    chk("rs_b0", 32'(bus.OUT_byte), 32'h5A);
    bus.IN_spiValid = 1'b1; bus.IN_spiData = 1'b1;
    tick();
    tick();
    bus.IN_spiValid = 1'b0; bus.IN_spiData = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_busy", 32'(bus.OUT_busy), 32'h0);
    chk("rs_byte", 32'(bus.OUT_byte), 32'h0);
    chk("rs_addr", 32'(bus.OUT_spiAddr), 32'h0);
    chk("rs_cancel", 32'(bus.OUT_spiCancel), 32'h0);
    bus.IN_req = 2'b11; bus.IN_len0 = 8'd0; bus.IN_len1 = 8'd0;
    tick();
    chk("rs_first_ack", 32'(bus.OUT_ack), 32'h1);
    bus.IN_req = 2'b00;
    tick();
    feed_byte(8'h96);
    chk("rs_post_byte", 32'(bus.OUT_byte), 32'h96);
    chk("rs_post_done", 32'(bus.OUT_done), 32'h1);
    repeat (3) tick();
    chk("rs_post_idle", 32'(bus.OUT_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_fetch_sched.md
# spi_fetch_sched

Fetch scheduler in front of the bit-serial SPI EEPROM reader. Two clients (e.g. the video tile fetcher and the audio sample fetcher) post byte-burst requests (24-bit start address, byte count). The block round-robin arbitrates between them and drives the reader's read/cancel controls. It assembles the MSB-first bit stream into bytes, routes each byte to the owning client, and ends the burst with a cancel and a chip-select recovery gap.

## Interface
- `LEN_W`, 8: width of burst length field; a burst transfers `len+1` bytes (1..2^LEN_W).
- `GAP_CYCLES`, 2: idle cycles after a cancel before the next read may start (≥1).

- `clk` in 1: clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `IN_req` in 2: request level per client; held until `OUT_ack`.
- `IN_addr0`, `IN_addr1` in 24: start byte address per client; sampled on grant.
- `IN_len0`, `IN_len1` in LEN_W: byte count minus one per client; sampled on grant.
- `IN_abort` in 2: owner aborts its burst; ignored from non-owner or when idle.
- `OUT_ack` out 2: one-cycle grant pulse, one-hot.
- `OUT_byte` out 8: assembled byte.
- `OUT_byteValid` out 2: one-hot owner strobe for `OUT_byte`.
- `OUT_done` out 2: one-cycle pulse with the last byte of a non-aborted burst.
- `OUT_busy` out 1: high whenever state ≠ IDLE.
- `OUT_spiAddr` out 24: start address to the reader.
- `OUT_spiRead` out 1: read start pulse.
- `OUT_spiCancel` out 1: cancel pulse.
- `IN_spiData` in 1: serial data bit.
- `IN_spiValid` in 1: data bit valid (reader in data phase).
- `IN_spiByte` in 1: current bit is bit 0 (last) of a byte.

## Operation
- States: IDLE, START, STREAM, CANCEL, GAP.
- IDLE: if any `IN_req`, pick the winner and latch its addr/len/owner. The winner is the requested client when only one requests, else the client not served last. Go to START. The last-served pointer resets to client 1, so client 0 wins the first tie.
- START (1 cycle): `OUT_ack[owner]`=1, `OUT_spiRead`=1, `OUT_spiAddr`=latched addr. Clear the shift register and abort-pending flag. Go to STREAM.
- STREAM: on `IN_spiValid`, shift: `sh <= {sh[6:0], IN_spiData}`. When `IN_spiValid && IN_spiByte`, the byte is `{sh[6:0], IN_spiData}`; it is registered to `OUT_byte` with `OUT_byteValid[owner]`=1 next cycle. Byte counter starts at len and decrements per byte. A byte with counter==0 is the last one: it also sets `OUT_done[owner]`, and state goes to CANCEL.
- Abort: `IN_abort[owner]` in START or STREAM sets abort-pending. Abort-pending is acted on in STREAM only on a cycle with `IN_spiValid`=1 (reader in data phase). On that cycle: go to CANCEL, emit no byte from that cycle, no `OUT_done`. A byte completing the same cycle is dropped.
- CANCEL (1 cycle): `OUT_spiCancel`=1; then GAP.
- GAP: `GAP_CYCLES` cycles, then IDLE. `IN_spiValid`/data are ignored in CANCEL, GAP, IDLE, START.
- Requests arriving while busy wait at IDLE; `IN_req` dropped before ack is a legal withdrawal.
- Reset: state IDLE, pointer=1, all outputs 0 (`OUT_spiAddr`=0), counters/shift cleared. Reset mid-burst aborts without cancel pulse; the reader is reset by the same `rst` domain at system level.

## Timing
- Cycle 0: IDLE sees req. Cycle 1: START (ack, read). Cycle 2 onward: STREAM.
- Byte output latency: 1 cycle after the `IN_spiByte` cycle.
- Last byte at cycle t (output). `OUT_done` is at t. `OUT_spiCancel` is at t; the state is CANCEL during t. GAP covers t+1..t+GAP_CYCLES. IDLE is at t+GAP_CYCLES+1. The earliest next ack is at t+GAP_CYCLES+2.
- Minimum burst: len=0 gives exactly one `OUT_byteValid`, coincident with `OUT_done`.
- All outputs are registered; no combinational input→output paths.

## Test plan
- Single request: client 0, addr 0x012345, len 0. Reader model streams bits 1,0,1,0,0,1,0,1 → ack0 at cycle 1; `OUT_spiAddr`=0x012345 with read pulse; `OUT_byte`=0xA5, `OUT_byteValid`=2'b01 and `OUT_done`=2'b01 one cycle after the 8th bit; cancel pulse; busy low after 2 gap cycles.
- Multi-byte: client 1, len 3, bytes 0x11,0x22,0x33,0x44 → four `OUT_byteValid`=2'b10 strobes in order, done with 0x44, exactly one cancel.
- Round-robin: both requesting continuously → grants 0,1,0,1; each ack only after the previous burst's GAP ends.
- Early abort: client 0 asserts abort during START → no bytes delivered. Cancel asserts on the first `IN_spiValid` cycle; no `OUT_done`.
- Mid-burst abort: len 7, abort after 2 bytes → exactly 2 bytes delivered, then cancel, no done. A non-owner abort is ignored.
- Reset mid-STREAM: `rst`=1 for 1 cycle → all outputs 0 next cycle, state IDLE. A following request from client 0 is granted first.
